simon_dual_arbiter: RTL and testbench

Shares one SIMON_128256 core between two independent requesters, channels 0 and 1. Each channel holds its own key register. The arbiter grants the core round-robin and reloads the core key only when the owning channel changes or a channel's key was rewritten. It then sequences the core's key/data handshakes and returns results through a per-channel valid/ready response port. It sits between two bus-side clients and the core instance.

---
 rtl/simon_dual_arbiter.sv | 178 +++++++++++++++++
 tb/tb_simon_dual_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_dual_arbiter.sv
// simon_dual_arbiter
// Shares one SIMON 128/256 core between two requesters (channel 0 and 1).
// Each channel owns a key register. Jobs are granted round-robin. The core
// key is reloaded only when the owning channel changes or the granted
// channel's key was rewritten since the core last expanded it. Results come
// back on a per-channel valid/ready response port with a shared data bus.
//
// Ports
//   clk, nR                 clock, synchronous active-high reset
//   key_wr/key_in           per-channel key write strobe and value
//   req_valid/req_ready     per-channel job handshake (ready is a 1-cycle grant)
//   req_enc_dec/req_block   per-channel job: 1=encrypt, 0=decrypt; input block
//   rsp_valid/rsp_ready     per-channel result handshake
//   rsp_data                result block, shared by both channels
//   c_*                     controls to / status from the shared core
module simon_dual_arbiter #(
  parameter int N = 64,
  parameter int M = 4
) (
  input  logic                  clk,
  input  logic                  nR,
  input  logic [1:0]            key_wr,
  input  logic [1:0][M*N-1:0]   key_in,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_enc_dec,
  input  logic [1:0][2*N-1:0]   req_block,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [2*N-1:0]        rsp_data,
  output logic                  c_newData,
  output logic                  c_newKey,
  output logic                  c_enc_dec,
  output logic                  c_readData,
  output logic [2*N-1:0]        c_BLOCK,
  output logic [M*N-1:0]        c_KEY,
  input  logic                  c_loadData,
  input  logic                  c_loadKey,
  input  logic                  c_doneData,
  input  logic                  c_doneKey,
  input  logic [2*N-1:0]        c_outData
);

  typedef enum logic [2:0] {
    IDLE, KEY_REQ, KEY_WAIT, DATA_REQ, DATA_WAIT, RESP
  } state_t;

  state_t                 state_q, state_d;
  logic                   owner_q;
  logic                   last_grant_q;
  logic [1:0]             key_ok_q;
  logic [1:0]             key_fresh_q, key_fresh_d;
  logic [1:0][M*N-1:0]    key_q;
  logic                   job_enc_q;
  logic [2*N-1:0]         job_block_q;

  logic [1:0]             elig;
  logic                   grant_any;
  logic                   grant_ch;
  logic                   pref_ch;
  logic                   need_key;
  logic                   grant_go;

  // Round-robin: the channel after last_grant has priority; a lone eligible
  // channel wins regardless.
  always_comb begin
    elig      = req_valid & key_ok_q;
    grant_any = |elig;
    pref_ch   = ~last_grant_q;
    grant_ch  = elig[pref_ch] ? pref_ch : ~pref_ch;
    // A same-cycle key write on the granted channel forces a reload so the
    // job runs with the new key.
    need_key  = (grant_ch != owner_q) || !key_fresh_q[grant_ch] || key_wr[grant_ch];
    grant_go  = (state_q == IDLE) && grant_any && !nR;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    c_newKey   = 1'b0;
    c_newData  = 1'b0;
    c_readData = 1'b0;
    rsp_valid  = '0;
    c_KEY      = '0;
    c_BLOCK    = '0;
    c_enc_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          req_ready[grant_ch] = 1'b1;
          state_d = need_key ? KEY_REQ : DATA_REQ;
        end
      end
      KEY_REQ: begin
        c_KEY = key_q[owner_q];
        if (c_loadKey) begin
          c_newKey = 1'b1;
          state_d  = KEY_WAIT;
        end
      end
      KEY_WAIT: begin
        if (c_doneKey) state_d = DATA_REQ;
      end
      DATA_REQ: begin
        c_BLOCK   = job_block_q;
        c_enc_dec = job_enc_q;
        if (c_loadData) begin
          c_newData = 1'b1;
          state_d   = DATA_WAIT;
        end
      end
      DATA_WAIT: begin
        if (c_doneData) state_d = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          c_readData = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Nothing leaves the block while reset is held.
    if (nR) begin
      req_ready  = '0;
      c_newKey   = 1'b0;
      c_newData  = 1'b0;
      c_readData = 1'b0;
      rsp_valid  = '0;
      c_KEY      = '0;
      c_BLOCK    = '0;
      c_enc_dec  = 1'b0;
    end
  end

  // key_fresh[i] means the core currently holds channel i's key. A reload
  // invalidates the other channel; a key write invalidates its own channel
  // and takes precedence over a same-cycle key-done.
  always_comb begin
    key_fresh_d = key_fresh_q;
    if (state_q == KEY_WAIT && c_doneKey) key_fresh_d[owner_q] = 1'b1;
    if (grant_go && need_key) key_fresh_d[~grant_ch] = 1'b0;
    key_fresh_d = key_fresh_d & ~key_wr;
  end

  always_ff @(posedge clk) begin
    if (nR) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      key_ok_q     <= '0;
      key_fresh_q  <= '0;
      rsp_data     <= '0;
    end else begin
      state_q     <= state_d;
      key_fresh_q <= key_fresh_d;
      key_ok_q    <= key_ok_q | key_wr;
      if (grant_go) begin
        owner_q      <= grant_ch;
        last_grant_q <= grant_ch;
      end
      if (state_q == DATA_WAIT && c_doneData) rsp_data <= c_outData;
    end
  end

  // Key registers and the latched job carry data only.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (key_wr[i]) key_q[i] <= key_in[i];
    end
    if (grant_go) begin
      job_enc_q   <= req_enc_dec[grant_ch];
      job_block_q <= req_block[grant_ch];
    end
  end

endmodule

// File: tb/tb_simon_dual_arbiter.sv
module tb_simon_dual_arbiter;

  localparam logic [255:0] K0 =
    256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [255:0] K1 =
    256'h0123456789abcdef_fedcba9876543210_55aa55aa33cc33cc_0f0f0f0ff0f0f0f0;
  localparam logic [127:0] PT = 128'h74206e69206d6f6f_6d69732061207369;
  localparam logic [127:0] CT = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;
  localparam logic [127:0] B1 = 128'hdeadbeefcafef00d_0011223344556677;

  typedef logic [71:0][63:0] sched_t;

  logic                clk = 1'b0;
  logic                nR;
  logic [1:0]          key_wr;
  logic [1:0][255:0]   key_in;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_enc_dec;
  logic [1:0][127:0]   req_block;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [127:0]        rsp_data;
  logic                c_newData, c_newKey, c_enc_dec, c_readData;
  logic [127:0]        c_BLOCK;
  logic [255:0]        c_KEY;
  logic                c_loadData, c_loadKey, c_doneData, c_doneKey;
  logic [127:0]        c_outData;

  int checks = 0;
  int errors = 0;
  int nk_cnt = 0;
  int rd_cnt = 0;

  always #5 clk = ~clk;

  simon_dual_arbiter #(.N(64), .M(4)) dut (
    .clk(clk), .nR(nR), .key_wr(key_wr), .key_in(key_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_enc_dec(req_enc_dec),
    .req_block(req_block), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .c_newData(c_newData), .c_newKey(c_newKey),
    .c_enc_dec(c_enc_dec), .c_readData(c_readData), .c_BLOCK(c_BLOCK),
    .c_KEY(c_KEY), .c_loadData(c_loadData), .c_loadKey(c_loadKey),
    .c_doneData(c_doneData), .c_doneKey(c_doneKey), .c_outData(c_outData)
  );

  // SIMON 128/256 reference
  function automatic logic [63:0] ror(input logic [63:0] v, input int s);
    return (v >> s) | (v << (64 - s));
  endfunction

  function automatic logic [63:0] sf(input logic [63:0] x);
    return ({x[62:0], x[63]} & {x[55:0], x[63:56]}) ^ {x[61:0], x[63:62]};
  endfunction

  function automatic sched_t sched(input logic [255:0] key);
    sched_t      k;
    logic [63:0] t;
    logic [61:0] zz;
    zz = 62'b11010001111001101011011000100000010111000011001010010011101111;
    k  = '0;
    for (int i = 0; i < 4; i++) k[i] = key[64*i +: 64];
    for (int i = 4; i < 72; i++) begin
      t    = ror(k[i-1], 3) ^ k[i-3];
      t    = t ^ ror(t, 1);
      k[i] = ~k[i-4] ^ t ^ {63'd0, zz[61 - ((i - 4) % 62)]} ^ 64'd3;
    end
    return k;
  endfunction

  function automatic logic [127:0] crypt(input sched_t k, input logic enc,
                                         input logic [127:0] b);
    logic [63:0] x, y, t;
    x = b[127:64];
    y = b[63:0];
    if (enc) begin
      for (int i = 0; i < 72; i++) begin
        t = x; x = y ^ sf(x) ^ k[i]; y = t;
      end
    end else begin
      for (int i = 71; i >= 0; i--) begin
        t = y; y = x ^ sf(y) ^ k[i]; x = t;
      end
    end
    return {x, y};
  endfunction

  // Behavioural core: key expansion takes 3 cycles, a block 4 cycles.
  sched_t       ks;
  int           kcnt, dcnt;
  logic [127:0] pend;

  always @(posedge clk) begin
    if (nR) begin
      c_loadKey  <= 1'b1;
      c_loadData <= 1'b1;
      c_doneKey  <= 1'b0;
      c_doneData <= 1'b0;
      c_outData  <= '0;
      kcnt       <= 0;
      dcnt       <= 0;
    end else begin
      if (c_newKey) begin
        ks        <= sched(c_KEY);
        c_loadKey <= 1'b0;
        c_doneKey <= 1'b0;
        kcnt      <= 3;
      end else if (kcnt > 0) begin
        kcnt <= kcnt - 1;
        if (kcnt == 1) begin
          c_doneKey <= 1'b1;
          c_loadKey <= 1'b1;
        end
      end
      if (c_newData) begin
        pend       <= crypt(ks, c_enc_dec, c_BLOCK);
        c_loadData <= 1'b0;
        c_doneData <= 1'b0;
        dcnt       <= 4;
      end else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) begin
          c_doneData <= 1'b1;
          c_outData  <= pend;
        end
      end
      if (c_readData) begin
        c_doneData <= 1'b0;
        c_loadData <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (c_newKey)   nk_cnt <= nk_cnt + 1;
    if (c_readData) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_key(input int ch, input logic [255:0] k);
    key_in[ch] = k;
    key_wr[ch] = 1'b1;
    step(1);
    key_wr[ch] = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk($sformatf("%s_ctl", tag),
        256'({req_ready, rsp_valid, c_newData, c_newKey, c_enc_dec, c_readData}), 256'd0);
    chk($sformatf("%s_blk", tag), 256'(c_BLOCK), 256'd0);
    chk($sformatf("%s_key", tag), c_KEY, 256'd0);
    chk($sformatf("%s_rsp", tag), 256'(rsp_data), 256'd0);
  endtask

  // Wait (bounded) for req_ready[ch] at a falling edge, complete the grant.
  task automatic wait_grant(input int ch, output bit got);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready[ch]) got = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid[ch] = 1'b0;
  endtask

  task automatic run_job(input string tag, input int ch, input logic enc,
                         input logic [127:0] blk, input logic [127:0] exp,
                         input int exp_nk);
    bit got;
    int nk0;
    nk0 = nk_cnt;
    req_enc_dec[ch] = enc;
    req_block[ch]   = blk;
    req_valid[ch]   = 1'b1;
    wait_grant(ch, got);
    chk($sformatf("%s_grant", tag), 256'(got), 256'd1);
    if (exp_nk == 0) begin
      @(negedge clk);
      chk($sformatf("%s_latency", tag), 256'(c_newData), 256'd1);
    end
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid[ch]) got = 1'b1;
    end
    chk($sformatf("%s_rsp_valid", tag), 256'(got), 256'd1);
    chk($sformatf("%s_data", tag), 256'(rsp_data), 256'(exp));
    rsp_ready[ch] = 1'b1;
    step(1);
    rsp_ready[ch] = 1'b0;
    chk($sformatf("%s_newkey_count", tag), 256'(nk_cnt - nk0), 256'(exp_nk));
    chk($sformatf("%s_rsp_clear", tag), 256'(rsp_valid), 256'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] e1;
    bit           got, bad_a, bad_b, bad_c, bad_d;
    int           gcnt, rcnt, nk0, rd0;
    logic         gch [4];
    logic         rch [4];
    logic [127:0] rdat [4];
    int           rnk [4];

    e1 = crypt(sched(K1), 1'b1, B1);

    nR = 1'b1; key_wr = '0; key_in = '0; req_valid = '0; req_enc_dec = '0;
    req_block = '0; rsp_ready = '0;
    step(3);
    chk_zero("reset");
    nR = 1'b0;
    step(2);
    chk("idle_no_grant", 256'({req_ready, rsp_valid}), 256'd0);

    // Test 1: first job on channel 0 loads the key once.
    write_key(0, K0);
    run_job("t1_enc", 0, 1'b1, PT, CT, 1);

    // Test 2: same owner, fresh key -> no reload; then decrypt.
    run_job("t2_enc", 0, 1'b1, PT, CT, 0);
    run_job("t2_dec", 0, 1'b0, CT, PT, 0);

    // Test 4: channel 1 without a key is never granted.
    req_enc_dec[1] = 1'b1;
    req_block[1]   = B1;
    req_valid[1]   = 1'b1;
    bad_a = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[1]) bad_a = 1'b1;
    end
    step(1);
    chk("t4_no_key_no_grant", 256'(bad_a), 256'd0);
    write_key(1, K1);
    run_job("t4_ch1", 1, 1'b1, B1, e1, 1);

    // Test 3: both channels requesting -> alternate with a reload each time.
    req_enc_dec  = 2'b01;
    req_block[0] = PT;
    req_block[1] = e1;
    req_valid    = 2'b11;
    rsp_ready    = 2'b11;
    gcnt = 0; rcnt = 0; nk0 = nk_cnt;
    for (int i = 0; i < 3000 && rcnt < 4; i++) begin
      @(negedge clk);
      if ((req_ready & req_valid) != 2'b00 && gcnt < 4) begin
        gch[gcnt] = req_ready[1];
        gcnt++;
      end
      if ((rsp_valid & rsp_ready) != 2'b00 && rcnt < 4) begin
        rch[rcnt]  = rsp_valid[1];
        rdat[rcnt] = rsp_data;
        rnk[rcnt]  = nk_cnt - nk0;
        rcnt++;
      end
      if (gcnt == 4 && req_valid != 2'b00) begin
        @(posedge clk);
        #1;
        req_valid = 2'b00;
      end
    end
    @(posedge clk);
    #1;
    rsp_ready = 2'b00;
    chk("t3_grant_count", 256'(gcnt), 256'd4);
    chk("t3_rsp_count", 256'(rcnt), 256'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_grant%0d_ch", i), 256'(gch[i]), 256'(i % 2));
      chk($sformatf("t3_rsp%0d_ch", i), 256'(rch[i]), 256'(i % 2));
      chk($sformatf("t3_rsp%0d_data", i), 256'(rdat[i]), 256'((i % 2 == 0) ? CT : B1));
      chk($sformatf("t3_rsp%0d_reloads", i), 256'(rnk[i]), 256'(i + 1));
    end

    // Test 5: response back-pressure holds everything.
    req_enc_dec  = 2'b11;
    req_block[0] = PT;
    req_block[1] = B1;
    req_valid    = 2'b11;
    wait_grant(0, got);
    chk("t5_grant", 256'(got), 256'd1);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) got = 1'b1;
    end
    chk("t5_rsp_valid", 256'(got), 256'd1);
    bad_a = 1'b0; bad_b = 1'b0; bad_c = 1'b0; bad_d = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b01) bad_a = 1'b1;
      if (rsp_data !== CT)     bad_b = 1'b1;
      if (c_readData !== 1'b0) bad_c = 1'b1;
      if (req_ready !== 2'b00) bad_d = 1'b1;
    end
    chk("t5_valid_held", 256'(bad_a), 256'd0);
    chk("t5_data_stable", 256'(bad_b), 256'd0);
    chk("t5_no_readdata", 256'(bad_c), 256'd0);
    chk("t5_no_grant", 256'(bad_d), 256'd0);
    @(posedge clk);
    #1;
    rd0          = rd_cnt;
    req_valid[1] = 1'b0;
    rsp_ready[0] = 1'b1;
    step(1);
    rsp_ready[0] = 1'b0;
    step(3);
    chk("t5_one_readdata", 256'(rd_cnt - rd0), 256'd1);
    chk("t5_rsp_cleared", 256'(rsp_valid), 256'd0);

    // Test 6a: reset during KEY_WAIT.
    write_key(0, K0);
    req_enc_dec[0] = 1'b1;
    req_block[0]   = PT;
    req_valid[0]   = 1'b1;
    wait_grant(0, got);
    chk("t6a_grant", 256'(got), 256'd1);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (c_newKey) got = 1'b1;
    end
    chk("t6a_newkey", 256'(got), 256'd1);
    @(posedge clk);
    #1;
    nR = 1'b1;
    step(1);
    chk_zero("t6a_reset");
    nR = 1'b0;
    bad_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) bad_a = 1'b1;
    end
    step(1);
    chk("t6a_no_rsp", 256'(bad_a), 256'd0);

    // Test 6b: reset during DATA_WAIT.
    write_key(0, K0);
    req_valid[0] = 1'b1;
    wait_grant(0, got);
    chk("t6b_grant", 256'(got), 256'd1);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (c_newData) got = 1'b1;
    end
    chk("t6b_newdata", 256'(got), 256'd1);
    @(posedge clk);
    #1;
    nR = 1'b1;
    step(1);
    chk_zero("t6b_reset");
    nR = 1'b0;
    bad_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) bad_a = 1'b1;
    end
    step(1);
    chk("t6b_no_rsp", 256'(bad_a), 256'd0);

    write_key(0, K0);
    run_job("t6_fresh", 0, 1'b0, CT, PT, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
